dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// RV32I data-memory access controller: decodes byte/half/word loads and stores onto a
// word-wide memory with a registered read port; sub-word stores use read-modify-write.
module dmem_access_ctrl #(
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int REG_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]       req_wdata,
    output logic                       rsp_valid,
    output logic [REG_WIDTH-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_wr_en,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]       mem_wr_data,
    input  logic [REG_WIDTH-1:0]       mem_rd_data
);

    localparam int NUM_LANES = REG_WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    state_t                     state_reg;
    logic                       we_reg;
    logic [2:0]                 funct3_reg;
    logic [DMEM_ADDR_WIDTH-1:0] addr_reg;
    logic [15:0]                wdata_reg;

    logic                       req_ready_reg;
    logic                       rsp_valid_reg;
    logic                       rsp_err_reg;
    logic [REG_WIDTH-1:0]       rsp_rdata_reg;
    logic                       mem_wr_en_reg;
    logic [DMEM_ADDR_WIDTH-1:0] mem_addr_reg;
    logic [REG_WIDTH-1:0]       mem_wr_data_reg;

    logic                       handshake;
    logic                       req_illegal;
    logic                       req_is_sw;
    logic [DMEM_ADDR_WIDTH-1:0] req_word_addr;
    logic [DMEM_ADDR_WIDTH-1:0] cur_word_addr;
    logic [7:0]                 rd_lane [NUM_LANES];
    logic [REG_WIDTH-1:0]       merged_word;
    logic [7:0]                 load_byte;
    logic [15:0]                load_half;
    logic [REG_WIDTH-1:0]       load_data;

    assign handshake     = req_valid & req_ready_reg;
    assign req_is_sw     = req_we & (req_funct3 == F3_W);
    assign req_word_addr = {req_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
    assign cur_word_addr = {addr_reg[DMEM_ADDR_WIDTH-1:2], 2'b00};

    // Illegal size codes, unsigned stores, and misaligned half/word accesses are all rejected.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            F3_B:  req_illegal = 1'b0;
            F3_H:  req_illegal = req_addr[0];
            F3_W:  req_illegal = (req_addr[1:0] != 2'b00);
            F3_BU: req_illegal = req_we;
            F3_HU: req_illegal = req_we | req_addr[0];
            default: req_illegal = 1'b1;
        endcase
    end

    // Per-lane merge: lane takes store data when selected by size and offset, else the read word.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_en;
            logic [7:0] st_byte;

            assign rd_lane[gi] = mem_rd_data[8*gi +: 8];
            assign lane_en     = (funct3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == LANE)
                                                            : (addr_reg[1] == LANE[1]);
            assign st_byte     = (funct3_reg[1:0] == 2'b00 || !LANE[0]) ? wdata_reg[7:0]
                                                                        : wdata_reg[15:8];
            assign merged_word[8*gi +: 8] = lane_en ? st_byte : rd_lane[gi];
        end
    endgenerate

    assign load_byte = rd_lane[addr_reg[1:0]];
    assign load_half = addr_reg[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

    always_comb begin
        load_data = mem_rd_data;
        case (funct3_reg)
            F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_data = {{16{load_half[15]}}, load_half};
            F3_BU:   load_data = {24'd0, load_byte};
            F3_HU:   load_data = {16'd0, load_half};
            default: load_data = mem_rd_data;
        endcase
    end

    // Every output is registered: each branch loads the values for the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            we_reg          <= 1'b0;
            funct3_reg      <= 3'd0;
            addr_reg        <= '0;
            wdata_reg       <= 16'd0;
            req_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_err_reg     <= 1'b0;
            rsp_rdata_reg   <= '0;
            mem_wr_en_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        we_reg        <= req_we;
                        funct3_reg    <= req_funct3;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata[15:0];
                        req_ready_reg <= 1'b0;
                        if (req_illegal) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end else begin
                            state_reg    <= ACCESS;
                            mem_addr_reg <= req_word_addr;
                            if (req_is_sw) begin
                                mem_wr_en_reg   <= 1'b1;
                                mem_wr_data_reg <= req_wdata;
                            end
                        end
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_wr_en_reg   <= 1'b0;
                    mem_wr_data_reg <= '0;
                    mem_addr_reg    <= '0;
                    if (we_reg && funct3_reg == F3_W) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= '0;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (we_reg) begin
                        state_reg       <= WRITE;
                        mem_addr_reg    <= cur_word_addr;
                        mem_wr_en_reg   <= 1'b1;
                        mem_wr_data_reg <= merged_word;
                    end else begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= load_data;
                    end
                end
                WRITE: begin
                    state_reg       <= RESP;
                    mem_wr_en_reg   <= 1'b0;
                    mem_wr_data_reg <= '0;
                    mem_addr_reg    <= '0;
                    rsp_valid_reg   <= 1'b1;
                    rsp_err_reg     <= 1'b0;
                    rsp_rdata_reg   <= '0;
                end
                RESP: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg       <= IDLE;
                    req_ready_reg   <= 1'b0;
                    rsp_valid_reg   <= 1'b0;
                    mem_wr_en_reg   <= 1'b0;
                    mem_addr_reg    <= '0;
                    mem_wr_data_reg <= '0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign mem_wr_en   = mem_wr_en_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a behavioural word memory with registered read,
// and a scoreboard of expected responses popped when rsp_valid appears.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic        preload;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr_cyc;
        logic [31:0] wr_data;
        logic [9:0]  addr1;
    } exp_t;

    exp_t sb_q[$];

    dmem_access_ctrl #(.DMEM_ADDR_WIDTH(10), .REG_WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: bytes 0x10..0x13 = 80,7F,FF,01 little-endian.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[4] <= 32'h01FF7F80;
        end else if (mem_wr_en) begin
            mem[mem_addr[9:2]] <= mem_wr_data;
        end
        mem_rd_data <= mem[mem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wr_cyc, input logic [31:0] exp_wr_data);
        exp_t        e;
        exp_t        got;
        int          wait_cyc;
        int          rsp_cyc;
        int          wr_cnt;
        int          wr_cyc;
        int          stray;
        int          addr_nz;
        logic [31:0] wr_dat;
        logic [9:0]  wr_addr;
        logic [9:0]  addr1;
        logic [31:0] got_rdata;
        logic        got_err;
        logic        ready_after;
        logic        valid_after;
        logic        done;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.lat     = exp_lat;
        e.wr_cyc  = exp_wr_cyc;
        e.wr_data = exp_wr_data;
        e.addr1   = exp_err ? 10'd0 : {addr[9:2], 2'b00};
        sb_q.push_back(e);

        wait_cyc = 0;
        @(negedge clk);
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        rsp_cyc = 0; wr_cnt = 0; wr_cyc = 0; stray = 0; addr_nz = 0;
        wr_dat = 0; wr_addr = 0; addr1 = 0; got_rdata = 0; got_err = 0;
        ready_after = 0; valid_after = 0; done = 0;
        for (int n = 1; n <= 10 && !done; n++) begin
            if (n == 1) addr1 = mem_addr;
            if (mem_addr != 0) addr_nz++;
            if (mem_wr_en) begin
                wr_cnt++;
                wr_cyc  = n;
                wr_dat  = mem_wr_data;
                wr_addr = mem_addr;
            end else if (mem_wr_data != 0) begin
                stray++;
            end
            if (rsp_cyc != 0 && n == rsp_cyc + 1) begin
                ready_after = req_ready;
                valid_after = rsp_valid;
                done = 1;
            end else if (rsp_valid && rsp_cyc == 0) begin
                rsp_cyc   = n;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
            end
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end

        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", name);
            return;
        end
        got = sb_q.pop_front();
        check({name, "_rsp_lat"}, rsp_cyc, got.lat);
        check({name, "_rdata"}, got_rdata, got.rdata);
        check({name, "_err"}, {31'd0, got_err}, {31'd0, got.err});
        check({name, "_rsp_single"}, {31'd0, valid_after}, 32'd0);
        check({name, "_ready_after"}, {31'd0, ready_after}, 32'd1);
        check({name, "_addr_a1"}, {22'd0, addr1}, {22'd0, got.addr1});
        check({name, "_wr_count"}, wr_cnt, (got.wr_cyc != 0) ? 1 : 0);
        check({name, "_wr_cycle"}, wr_cyc, got.wr_cyc);
        check({name, "_wdata_idle0"}, stray, 0);
        if (got.wr_cyc != 0) begin
            check({name, "_wr_data"}, wr_dat, got.wr_data);
            check({name, "_wr_addr"}, {22'd0, wr_addr}, {22'd0, got.addr1});
        end
        if (got.err) check({name, "_addr_stays0"}, addr_nz, 0);
    endtask

    initial begin
        int rst_wr;
        int rst_rsp;
        reset_n    = 1'b0;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 10'd0;
        req_wdata  = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wr_data", mem_wr_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Loads: response in A+3, no write.
        do_req("LB_10",  1'b0, 3'b000, 10'h010, 32'd0, 32'hFFFFFF80, 1'b0, 3, 0, 32'd0);
        do_req("LBU_10", 1'b0, 3'b100, 10'h010, 32'd0, 32'h00000080, 1'b0, 3, 0, 32'd0);
        do_req("LB_11",  1'b0, 3'b000, 10'h011, 32'd0, 32'h0000007F, 1'b0, 3, 0, 32'd0);
        do_req("LB_12",  1'b0, 3'b000, 10'h012, 32'd0, 32'hFFFFFFFF, 1'b0, 3, 0, 32'd0);
        do_req("LBU_13", 1'b0, 3'b100, 10'h013, 32'd0, 32'h00000001, 1'b0, 3, 0, 32'd0);
        do_req("LH_12",  1'b0, 3'b001, 10'h012, 32'd0, 32'h000001FF, 1'b0, 3, 0, 32'd0);
        do_req("LH_10",  1'b0, 3'b001, 10'h010, 32'd0, 32'h00007F80, 1'b0, 3, 0, 32'd0);
        do_req("LHU_10", 1'b0, 3'b101, 10'h010, 32'd0, 32'h00007F80, 1'b0, 3, 0, 32'd0);
        do_req("LW_10",  1'b0, 3'b010, 10'h010, 32'd0, 32'h01FF7F80, 1'b0, 3, 0, 32'd0);

        // Stores: SB read-modify-write, SW single write.
        do_req("SB_11",  1'b1, 3'b000, 10'h011, 32'h123456AB, 32'd0, 1'b0, 4, 3, 32'h01FFAB80);
        do_req("LW_10b", 1'b0, 3'b010, 10'h010, 32'd0, 32'h01FFAB80, 1'b0, 3, 0, 32'd0);
        do_req("SW_14",  1'b1, 3'b010, 10'h014, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 32'hDEADBEEF);
        do_req("LW_14",  1'b0, 3'b010, 10'h014, 32'd0, 32'hDEADBEEF, 1'b0, 3, 0, 32'd0);
        do_req("SH_16",  1'b1, 3'b001, 10'h016, 32'hFFFFC0DE, 32'd0, 1'b0, 4, 3, 32'hC0DEBEEF);
        do_req("LHU_16", 1'b0, 3'b101, 10'h016, 32'd0, 32'h0000C0DE, 1'b0, 3, 0, 32'd0);
        do_req("LH_16",  1'b0, 3'b001, 10'h016, 32'd0, 32'hFFFFC0DE, 1'b0, 3, 0, 32'd0);

        // Rejected requests: response in A+1 with rsp_err, no memory activity.
        do_req("ERR_LW_12",  1'b0, 3'b010, 10'h012, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0);
        do_req("ERR_SH_11",  1'b1, 3'b001, 10'h011, 32'h5555, 32'd0, 1'b1, 1, 0, 32'd0);
        do_req("ERR_F3_011", 1'b0, 3'b011, 10'h010, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0);
        do_req("ERR_SBU",    1'b1, 3'b100, 10'h010, 32'h77, 32'd0, 1'b1, 1, 0, 32'd0);

        // Reset pulsed during CAPTURE of SH 0x10: request must vanish.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 10'h010;
        req_wdata  = 32'h00009999;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("midrst_mem_addr", {22'd0, mem_addr}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rst_wr = 0;
        rst_rsp = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) check("midrst_ready_after", {31'd0, req_ready}, 32'd1);
            if (mem_wr_en) rst_wr++;
            if (rsp_valid) rst_rsp++;
        end
        check("midrst_no_write", rst_wr, 0);
        check("midrst_no_rsp", rst_rsp, 0);
        do_req("LW_10_post", 1'b0, 3'b010, 10'h010, 32'd0, 32'h01FFAB80, 1'b0, 3, 0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
